// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared states, screen widths and scroll-limit helper for frame_scheduler.
package frame_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BG_START,
        BG_RUN,
        SPR_START,
        SPR_RUN,
        SCROLL
    } state_t;

    localparam int SCREEN_X_W         = 8;
    localparam int SCREEN_Y_W         = 7;
    localparam int TILEMAP_LENGTH_DEF = 100;
    localparam int SCREEN_TILES_DEF   = 20;
    localparam int MAX_OFFSET         = TILEMAP_LENGTH_DEF - SCREEN_TILES_DEF;

    function automatic int max_offset(input int tilemap_length, input int screen_tiles);
        return tilemap_length - screen_tiles;
    endfunction

endpackage

// File: rtl/frame_scheduler_plot_mux.sv
// plot_mux: registered 2:1 pixel-stream selector; plot is gated low and x/y/colour hold
// whenever no source is enabled.
module plot_mux
    import frame_sched_pkg::*;
#(
    parameter int COLOR_DEPTH = 9
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   i_en,
    input  logic                   i_sel,
    input  logic [SCREEN_X_W-1:0]  i_a_x,
    input  logic [SCREEN_Y_W-1:0]  i_a_y,
    input  logic [COLOR_DEPTH-1:0] i_a_color,
    input  logic                   i_a_plot,
    input  logic [SCREEN_X_W-1:0]  i_b_x,
    input  logic [SCREEN_Y_W-1:0]  i_b_y,
    input  logic [COLOR_DEPTH-1:0] i_b_color,
    input  logic                   i_b_plot,
    output logic [SCREEN_X_W-1:0]  o_x,
    output logic [SCREEN_Y_W-1:0]  o_y,
    output logic [COLOR_DEPTH-1:0] o_color,
    output logic                   o_plot
);

    logic [SCREEN_X_W-1:0]  r_x;
    logic [SCREEN_Y_W-1:0]  r_y;
    logic [COLOR_DEPTH-1:0] r_color;
    logic                   r_plot;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_plot  <= 1'b0;
        end else begin
            r_plot <= i_en && (i_sel ? i_b_plot : i_a_plot);
            if (i_en) begin
                r_x     <= i_sel ? i_b_x : i_a_x;
                r_y     <= i_sel ? i_b_y : i_a_y;
                r_color <= i_sel ? i_b_color : i_a_color;
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_color = r_color;
    assign o_plot  = r_plot;

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame background/sprite render sequencer owning the VGA write port.
// Define SPRITE_PASS_EN to include the sprite pass; otherwise background only.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int TILEMAP_LENGTH = TILEMAP_LENGTH_DEF,
    parameter int SCREEN_TILES   = SCREEN_TILES_DEF,
    parameter int COLOR_DEPTH    = 9,
    parameter int OFFSET_W       = 7
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic                   scroll_left,
    input  logic                   scroll_right,
    output logic                   bg_enable,
    input  logic                   bg_done,
    input  logic [SCREEN_X_W-1:0]  bg_x,
    input  logic [SCREEN_Y_W-1:0]  bg_y,
    input  logic [COLOR_DEPTH-1:0] bg_color,
    input  logic                   bg_plot,
    output logic                   spr_start,
    input  logic                   spr_done,
    input  logic [SCREEN_X_W-1:0]  spr_x,
    input  logic [SCREEN_Y_W-1:0]  spr_y,
    input  logic [COLOR_DEPTH-1:0] spr_color,
    input  logic                   spr_plot,
    output logic [SCREEN_X_W-1:0]  vga_x,
    output logic [SCREEN_Y_W-1:0]  vga_y,
    output logic [COLOR_DEPTH-1:0] vga_color,
    output logic                   vga_plot,
    output logic [OFFSET_W-1:0]    x_offset,
    output logic                   busy,
    output logic                   frame_overrun
);

    localparam logic [OFFSET_W-1:0] OFFSET_MAX = OFFSET_W'(max_offset(TILEMAP_LENGTH, SCREEN_TILES));

    state_t              r_state;
    state_t              w_next;
    logic [OFFSET_W-1:0] r_x_offset;
    logic [OFFSET_W-1:0] w_x_next;
    logic                w_bg_sel;
    logic                w_spr_sel;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_x_offset <= '0;
        end else begin
            r_state    <= w_next;
            r_x_offset <= w_x_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (frame_tick) w_next = BG_START;
            BG_START:  if (!bg_done) w_next = BG_RUN;
`ifdef SPRITE_PASS_EN
            BG_RUN:    if (bg_done) w_next = SPR_START;
            SPR_START: w_next = SPR_RUN;
            SPR_RUN:   if (spr_done) w_next = SCROLL;
`else
            BG_RUN:    if (bg_done) w_next = SCROLL;
`endif
            SCROLL:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Opposing requests cancel; both limits saturate rather than wrap.
    always_comb begin
        w_x_next = r_x_offset;
        if (r_state == SCROLL) begin
            if (scroll_right && !scroll_left && r_x_offset < OFFSET_MAX)
                w_x_next = r_x_offset + 1'b1;
            else if (scroll_left && !scroll_right && r_x_offset != '0)
                w_x_next = r_x_offset - 1'b1;
        end
    end

    assign w_bg_sel = (r_state == BG_START) || (r_state == BG_RUN);
`ifdef SPRITE_PASS_EN
    assign w_spr_sel = (r_state == SPR_START) || (r_state == SPR_RUN);
    assign spr_start = r_state == SPR_START;
`else
    logic w_unused_spr_done;
    assign w_unused_spr_done = spr_done;
    assign w_spr_sel = 1'b0;
    assign spr_start = 1'b0;
`endif

    assign bg_enable     = r_state == BG_START;
    assign busy          = r_state != IDLE;
    assign frame_overrun = frame_tick && busy;
    assign x_offset      = r_x_offset;

    plot_mux #(
        .COLOR_DEPTH(COLOR_DEPTH)
    ) u_plot_mux (
        .clock    (clock),
        .resetn   (resetn),
        .i_en     (w_bg_sel || w_spr_sel),
        .i_sel    (w_spr_sel),
        .i_a_x    (bg_x),
        .i_a_y    (bg_y),
        .i_a_color(bg_color),
        .i_a_plot (bg_plot),
        .i_b_x    (spr_x),
        .i_b_y    (spr_y),
        .i_b_color(spr_color),
        .i_b_plot (spr_plot),
        .o_x      (vga_x),
        .o_y      (vga_y),
        .o_color  (vga_color),
        .o_plot   (vga_plot)
    );

endmodule
